// File: rtl/maxpool_mul_arbiter.sv
// ---------------------------------------------------------------------------
// maxpool_mul_arbiter
//
// Shares one external pipelined unsigned 16x8->24 multiplier among NUM_REQ
// requesters in the maxPool address path. A round-robin arbiter picks one
// requester per cycle and drives its operands straight onto the multiplier
// inputs. A {valid,id} tag pipeline runs alongside the multiplier in lockstep,
// so the product appears at the response port together with the id of the
// requester that issued it. Response backpressure stalls the whole multiplier
// pipeline through mul_ce.
//
// Ports
//   clk        clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   req_valid  per-requester request valid                  [NUM_REQ]
//   req_a      packed multiplicands, requester i at [16*i+:16]
//   req_b      packed multipliers,   requester i at [8*i+:8]
//   req_ready  one-hot accept, combinational from the grant [NUM_REQ]
//   rsp_valid  result valid at pipeline head
//   rsp_id     requester index of the result                [ID_W]
//   rsp_p      product, passed through from mul_dout        [24]
//   rsp_ready  consumer accepts result
//   mul_ce     clock enable to the shared multiplier
//   mul_din0   multiplier operand a                         [16]
//   mul_din1   multiplier operand b                         [8]
//   mul_dout   multiplier product a*b                       [24]
// ---------------------------------------------------------------------------
module maxpool_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*8-1:0]  req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [23:0]           rsp_p,
  input  logic                  rsp_ready,
  output logic                  mul_ce,
  output logic [15:0]           mul_din0,
  output logic [7:0]            mul_din1,
  input  logic [23:0]           mul_dout
);

  logic [ID_W-1:0] rr_ptr;
  logic            tag_valid [MUL_LAT];
  logic [ID_W-1:0] tag_id    [MUL_LAT];

  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic            issue;
  logic [ID_W-1:0] rr_next;

  // Response head is the last tag stage; the product needs no alignment
  // because the multiplier and the tag pipeline advance on the same ce edges.
  assign rsp_valid = tag_valid[MUL_LAT-1];
  assign rsp_id    = tag_id[MUL_LAT-1];
  assign rsp_p     = mul_dout;

  // Holding a valid head that the consumer refuses freezes everything.
  assign mul_ce = ~(rsp_valid & ~rsp_ready);

  // Round-robin search starting at rr_ptr, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    int cand;
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  // Reset gating keeps req_ready and the operand buses at zero while reset
  // is held, even if requesters are already asserting valid.
  assign issue   = grant_any & mul_ce & ~reset;
  assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0             = req_a[16*grant_idx +: 16];
      mul_din1             = req_b[8*grant_idx +: 8];
    end
  end

  // NOTE: the tag array is reset because its valid bits are what suppress
  // responses for stale multiplier contents; the multiplier data itself is
  // left unreset outside this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_valid[k] <= 1'b0;
        tag_id[k]    <= '0;
      end
    end else if (mul_ce) begin
      // NOTE: non-blocking assignments let each stage read the previous
      // stage's old value, giving a true shift register.
      tag_valid[0] <= issue;
      tag_id[0]    <= issue ? grant_idx : '0;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
      if (issue) rr_ptr <= rr_next;
    end
  end

endmodule
